// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and defaults for the IF-stage fetch sequencer
// Purpose: FSM state encoding and default constants used by the fetch sequencer and its bench.
// Ports: none (package).
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
  localparam int          MAX_WAIT_DEF  = 16;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory request/response bundle
// Purpose: groups the imem fetch handshake between the fetch sequencer and imem.
// Signals: imem_req/imem_addr (sequencer -> imem), imem_ready/imem_rdata (imem -> sequencer).
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - saturating imem wait counter with sticky timeout flag
// Purpose: counts cycles an imem request has been waiting; fetch_err latches once MAX_WAIT is reached.
// Ports: clk, rst (async active-low), clr (restart count), inc (one more wait cycle), fetch_err (sticky).
module fetch_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic fetch_err
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] CNT_MAX = W'(MAX_WAIT);

  logic [W-1:0] wait_cnt_q, wait_cnt_d;
  logic         fetch_err_q, fetch_err_d;

  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
    if (clr) begin
      wait_cnt_d = '0;
    end else if (inc && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    // Flag sets on the same edge the count reaches the limit; waiting carries on.
    if (!clr && inc && (wait_cnt_d == CNT_MAX)) begin
      fetch_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - IF-stage control sequencer
// Purpose: drives pc load/next-PC, the imem request handshake and IF/ID write/flush; handles
//          variable-latency imem, ID stalls, EX redirects (draining in-flight fetches) and fetch timeout.
// Ports: clk, rst (async active-low), pc_cur, pc_sel_ex/pc_target_ex (EX redirect), stall_id,
//        imem (master side of fetch_sequencer_if), pc_next/pc_we, if_id_we/if_id_flush/instr_out, fetch_err.
module fetch_sequencer
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int          MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pc_cur,
  input  logic                      pc_sel_ex,
  input  logic [31:0]               pc_target_ex,
  input  logic                      stall_id,
  fetch_sequencer_if.master         imem,
  output logic [31:0]               pc_next,
  output logic                      pc_we,
  output logic                      if_id_we,
  output logic                      if_id_flush,
  output logic [31:0]               instr_out,
  output logic                      fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  hold_buf_q, hold_buf_d;
  logic [31:0]  stale_addr_q, stale_addr_d;
  logic [31:0]  pc_plus4;
  logic         redirect;
  logic         waiting_state;
  logic         timer_clr, timer_inc;
  logic         imem_req_c;

  assign pc_plus4      = pc_cur + 32'd4;
  assign redirect      = pc_sel_ex && (state_q != ST_IDLE);
  assign waiting_state = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign timer_clr     = redirect || (waiting_state && imem.imem_ready);
  assign timer_inc     = waiting_state && !imem.imem_ready && !redirect;

  // The request address captured in REQ is kept on the bus while draining,
  // since pc_cur has already moved to the redirect target.
  assign stale_addr_d   = (state_q == ST_REQ) ? pc_cur : stale_addr_q;
  assign imem.imem_addr = (state_q == ST_DRAIN) ? stale_addr_q : pc_cur;
  assign imem.imem_req  = imem_req_c;

  always_comb begin
    state_d     = state_q;
    hold_buf_d  = hold_buf_q;
    imem_req_c  = 1'b0;
    pc_we       = 1'b0;
    pc_next     = pc_plus4;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    instr_out   = NOP_INSTR;

    if (redirect) begin
      // Redirect beats stalls and discards any accepted or buffered word.
      pc_we       = 1'b1;
      pc_next     = pc_target_ex;
      if_id_we    = 1'b1;
      if_id_flush = 1'b1;
      hold_buf_d  = NOP_INSTR;
    end

    unique case (state_q)
      ST_IDLE: begin
        pc_next = RESET_PC;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        imem_req_c = 1'b1;
        if (redirect) begin
          state_d = imem.imem_ready ? ST_REQ : ST_DRAIN;
        end else if (imem.imem_ready) begin
          if (stall_id) begin
            hold_buf_d = imem.imem_rdata;
            state_d    = ST_HOLD;
          end else begin
            if_id_we  = 1'b1;
            instr_out = imem.imem_rdata;
            pc_we     = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (!stall_id) begin
          if_id_we  = 1'b1;
          instr_out = hold_buf_q;
          pc_we     = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_DRAIN: begin
        imem_req_c = 1'b1;
        // The response to the stale request is dropped.
        if (imem.imem_ready) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hold_buf_q   <= NOP_INSTR;
      stale_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      hold_buf_q   <= hold_buf_d;
      stale_addr_q <= stale_addr_d;
    end
  end

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (timer_clr),
    .inc       (timer_inc),
    .fetch_err (fetch_err)
  );

endmodule
